// File: rtl/tail_light_ctrl_pkg.sv
// Shared types and lamp patterns for the tail-light sequencer.
package tail_light_pkg;

  typedef enum logic [3:0] {
    IDLE,
    L1,
    L2,
    L3,
    R1,
    R2,
    R3,
    HAZ_ON,
    DARK
  } state_e;

  localparam logic [2:0] OFF = 3'b000;
  localparam logic [2:0] ONE = 3'b001;
  localparam logic [2:0] TWO = 3'b011;
  localparam logic [2:0] ALL = 3'b111;

endpackage

// File: rtl/tail_light_ctrl_prescaler.sv
// Step-rate prescaler: counts 0..TICK_DIV-1 and flags the last count as tick.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(TICK_DIV - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (clear || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/tail_light_ctrl.sv
// Sequential tail-light controller: turn sweeps, hazard flash and brake overlay,
// with lamps registered from the current state and a registered brake sample.
module tail_light_ctrl
  import tail_light_pkg::*;
#(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left,
  input  logic       right,
  input  logic       hazard,
  input  logic       brake,
  output logic [2:0] lights_l,
  output logic [2:0] lights_r
);

  state_e     state_q;
  state_e     state_d;
  logic       brake_q;
  logic [2:0] lights_l_q;
  logic [2:0] lights_l_d;
  logic [2:0] lights_r_q;
  logic [2:0] lights_r_d;
  logic       tick;
  logic       in_idle;

  // Holding the prescaler clear throughout IDLE restarts step timing on every exit.
  assign in_idle = (state_q == IDLE);

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clear(in_idle),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (hazard || (left && right)) state_d = HAZ_ON;
        else if (left)                 state_d = L1;
        else if (right)                state_d = R1;
      end
      L1:     if (tick) state_d = hazard ? HAZ_ON : L2;
      L2:     if (tick) state_d = hazard ? HAZ_ON : L3;
      L3:     if (tick) state_d = hazard ? HAZ_ON : DARK;
      R1:     if (tick) state_d = hazard ? HAZ_ON : R2;
      R2:     if (tick) state_d = hazard ? HAZ_ON : R3;
      R3:     if (tick) state_d = hazard ? HAZ_ON : DARK;
      HAZ_ON: if (tick) state_d = DARK;
      DARK:   if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Non-signalling sides default to the brake overlay; IDLE and DARK keep it on both.
  always_comb begin
    lights_l_d = brake_q ? ALL : OFF;
    lights_r_d = brake_q ? ALL : OFF;
    unique case (state_q)
      L1:     lights_l_d = ONE;
      L2:     lights_l_d = TWO;
      L3:     lights_l_d = ALL;
      R1:     lights_r_d = ONE;
      R2:     lights_r_d = TWO;
      R3:     lights_r_d = ALL;
      HAZ_ON: begin
        lights_l_d = ALL;
        lights_r_d = ALL;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      brake_q    <= 1'b0;
      lights_l_q <= OFF;
      lights_r_q <= OFF;
    end else begin
      state_q    <= state_d;
      brake_q    <= brake;
      lights_l_q <= lights_l_d;
      lights_r_q <= lights_r_d;
    end
  end

  assign lights_l = lights_l_q;
  assign lights_r = lights_r_q;

endmodule

// File: tb/tb_tail_light_ctrl.sv
// Bench for tail_light_ctrl: directed scenarios plus randomized traffic against
// a step-countdown reference model, on TICK_DIV=4 and TICK_DIV=1 instances.
module tb_tail_light_ctrl;

  logic       clk;
  logic       reset;
  logic       left, right, hazard, brake;
  logic [2:0] l4, r4, l1, r1;

  int checks;
  int failures;

  tail_light_ctrl #(.TICK_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .left(left), .right(right),
    .hazard(hazard), .brake(brake), .lights_l(l4), .lights_r(r4)
  );

  tail_light_ctrl #(.TICK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .left(left), .right(right),
    .hazard(hazard), .brake(brake), .lights_l(l1), .lights_r(r1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] M_IDLE  = 3'd0;
  localparam logic [2:0] M_LEFT  = 3'd1;
  localparam logic [2:0] M_RIGHT = 3'd2;
  localparam logic [2:0] M_HAZ   = 3'd3;
  localparam logic [2:0] M_DARK  = 3'd4;

  typedef struct packed {
    logic [2:0] mode;
    logic [1:0] step;
    logic [8:0] rem;
    logic [2:0] l;
    logic [2:0] r;
    logic       bd;
  } mdl_t;

  localparam mdl_t MRST = '{mode: 3'd0, step: 2'd1, rem: 9'd0, l: 3'd0, r: 3'd0, bd: 1'b0};

  mdl_t m4, m1;

  function automatic mdl_t mstep(mdl_t m, int div, logic lf, logic rt, logic hz, logic bk);
    mdl_t       n = m;
    logic [2:0] side = m.bd ? 3'b111 : 3'b000;
    logic [2:0] pat = 3'((1 << m.step) - 1);
    case (m.mode)
      M_LEFT:  begin n.l = pat;    n.r = side;   end
      M_RIGHT: begin n.l = side;   n.r = pat;    end
      M_HAZ:   begin n.l = 3'b111; n.r = 3'b111; end
      default: begin n.l = side;   n.r = side;   end
    endcase
    n.bd = bk;
    if (m.mode == M_IDLE) begin
      if (hz || (lf && rt)) begin n.mode = M_HAZ; n.rem = 9'(div); end
      else if (lf) begin n.mode = M_LEFT;  n.step = 2'd1; n.rem = 9'(div); end
      else if (rt) begin n.mode = M_RIGHT; n.step = 2'd1; n.rem = 9'(div); end
    end else begin
      n.rem = m.rem - 9'd1;
      if (n.rem == 9'd0) begin
        n.rem = 9'(div);
        case (m.mode)
          M_LEFT, M_RIGHT: begin
            if (hz) n.mode = M_HAZ;
            else if (m.step == 2'd3) n.mode = M_DARK;
            else n.step = m.step + 2'd1;
          end
          M_HAZ:   n.mode = M_DARK;
          default: n.mode = M_IDLE;
        endcase
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m4 <= MRST;
      m1 <= MRST;
    end else begin
      m4 <= mstep(m4, 4, left, right, hazard, brake);
      m1 <= mstep(m1, 1, left, right, hazard, brake);
    end
  end

  task automatic apply_reset;
    left = 0; right = 0; hazard = 0; brake = 0;
    @(negedge clk);
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    left = 0; right = 0; hazard = 0; brake = 0;
    repeat (2) @(negedge clk);
    checks += 2;
    if (l4 !== 3'b000 || r4 !== 3'b000) begin
      failures++; $display("FAIL reset_div4 got=%b/%b exp=000/000", l4, r4);
    end
    if (l1 !== 3'b000 || r1 !== 3'b000) begin
      failures++; $display("FAIL reset_div1 got=%b/%b exp=000/000", l1, r1);
    end
    reset = 1'b0;
  endtask

  task automatic test_left_pulse;
    logic [2:0] tbl [4] = '{3'b001, 3'b011, 3'b111, 3'b000};
    logic [2:0] exp;
    apply_reset();
    left = 1;
    @(negedge clk);
    left = 0;
    checks++;
    if (l4 !== 3'b000) begin
      failures++; $display("FAIL left_pulse_lat got=%b exp=000", l4);
    end
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      exp = (i <= 16) ? tbl[(i - 1) / 4] : 3'b000;
      checks++;
      if (l4 !== exp || r4 !== 3'b000) begin
        failures++; $display("FAIL left_pulse[%0d] got=%b/%b exp=%b/000", i, l4, r4, exp);
      end
    end
  endtask

  task automatic test_both_held;
    logic [2:0] exp;
    apply_reset();
    left = 1; right = 1;
    for (int i = 0; i <= 27; i++) begin
      @(negedge clk);
      exp = (i >= 1 && ((i - 1) % 9) < 4) ? 3'b111 : 3'b000;
      checks++;
      if (l4 !== exp || r4 !== exp) begin
        failures++; $display("FAIL both_held[%0d] got=%b/%b exp=%b/%b", i, l4, r4, exp, exp);
      end
    end
    left = 0; right = 0;
  endtask

  task automatic test_hazard_r2;
    apply_reset();
    right = 1;
    @(negedge clk);
    right = 0;
    repeat (5) @(negedge clk);
    hazard = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (l4 !== 3'b000 || r4 !== 3'b011) begin
      failures++; $display("FAIL hazard_r2_pre got=%b/%b exp=000/011", l4, r4);
    end
    @(negedge clk);
    checks++;
    if (l4 !== 3'b000 || r4 !== 3'b011) begin
      failures++; $display("FAIL hazard_r2_edge got=%b/%b exp=000/011", l4, r4);
    end
    @(negedge clk);
    hazard = 0;
    checks++;
    if (l4 !== 3'b111 || r4 !== 3'b111) begin
      failures++; $display("FAIL hazard_r2_on got=%b/%b exp=111/111", l4, r4);
    end
    @(negedge clk);
    checks++;
    if (l4 !== 3'b111 || r4 !== 3'b111) begin
      failures++; $display("FAIL hazard_r2_hold got=%b/%b exp=111/111", l4, r4);
    end
  endtask

  task automatic test_brake;
    logic [2:0] exp;
    apply_reset();
    brake = 1;
    @(negedge clk);
    checks++;
    if (l4 !== 3'b000 || r4 !== 3'b000) begin
      failures++; $display("FAIL brake_latency got=%b/%b exp=000/000", l4, r4);
    end
    @(negedge clk);
    checks++;
    if (l4 !== 3'b111 || r4 !== 3'b111) begin
      failures++; $display("FAIL brake_idle got=%b/%b exp=111/111", l4, r4);
    end
    left = 1;
    @(negedge clk);
    left = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      exp = (i <= 4) ? 3'b001 : 3'b011;
      checks++;
      if (l4 !== exp || r4 !== 3'b111) begin
        failures++; $display("FAIL brake_left[%0d] got=%b/%b exp=%b/111", i, l4, r4, exp);
      end
    end
    apply_reset();
    hazard = 1;
    @(negedge clk);
    hazard = 0;
    @(negedge clk);
    brake = 1;
    repeat (3) @(negedge clk);
    checks++;
    if (l4 !== 3'b111 || r4 !== 3'b111) begin
      failures++; $display("FAIL brake_haz got=%b/%b exp=111/111", l4, r4);
    end
    brake = 0;
  endtask

  task automatic test_reset_mid;
    logic [2:0] exp;
    apply_reset();
    left = 1;
    @(negedge clk);
    left = 0;
    repeat (9) @(negedge clk);
    checks++;
    if (l4 !== 3'b111) begin
      failures++; $display("FAIL mid_l3 got=%b exp=111", l4);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (l4 !== 3'b000 || r4 !== 3'b000) begin
      failures++; $display("FAIL mid_reset_async got=%b/%b exp=000/000", l4, r4);
    end
    left = 1;
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (l4 !== 3'b000) begin
      failures++; $display("FAIL mid_restart_lat got=%b exp=000", l4);
    end
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      exp = (i <= 4) ? 3'b001 : 3'b011;
      checks++;
      if (l4 !== exp || r4 !== 3'b000) begin
        failures++; $display("FAIL mid_restart[%0d] got=%b/%b exp=%b/000", i, l4, r4, exp);
      end
    end
    left = 0;
  endtask

  task automatic test_div1;
    logic [2:0] tbl [5] = '{3'b001, 3'b011, 3'b111, 3'b000, 3'b000};
    apply_reset();
    right = 1;
    @(negedge clk);
    checks++;
    if (r1 !== 3'b000) begin
      failures++; $display("FAIL div1_lat got=%b exp=000", r1);
    end
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      checks++;
      if (r1 !== tbl[(k - 1) % 5] || l1 !== 3'b000) begin
        failures++; $display("FAIL div1[%0d] got=%b/%b exp=000/%b", k, l1, r1, tbl[(k - 1) % 5]);
      end
    end
    right = 0;
  endtask

  task automatic test_random;
    apply_reset();
    for (int n = 0; n < 3000; n++) begin
      left   = ($urandom_range(0, 5) == 0);
      right  = ($urandom_range(0, 5) == 0);
      hazard = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) brake = ~brake;
      @(negedge clk);
      checks += 2;
      if (l4 !== m4.l || r4 !== m4.r) begin
        failures++; $display("FAIL rand_div4[%0d] got=%b/%b exp=%b/%b", n, l4, r4, m4.l, m4.r);
      end
      if (l1 !== m1.l || r1 !== m1.r) begin
        failures++; $display("FAIL rand_div1[%0d] got=%b/%b exp=%b/%b", n, l1, r1, m1.l, m1.r);
      end
      if ($urandom_range(0, 199) == 0) begin
        #2 reset = 1'b1;
        #1;
        checks++;
        if (l4 !== 3'b000 || r4 !== 3'b000 || l1 !== 3'b000 || r1 !== 3'b000) begin
          failures++; $display("FAIL rand_reset[%0d] got=%b/%b %b/%b exp=all 000", n, l4, r4, l1, r1);
        end
        #1 reset = 1'b0;
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_left_pulse();
    test_both_held();
    test_hazard_r2();
    test_brake();
    test_reset_mid();
    test_div1();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tail_light_ctrl.md
TAIL_LIGHT_CTRL -- requirements
Module: tail_light_ctrl

Interface
REQ-001 Parameter: TICK_DIV, default 4, clk cycles per sequence step (legal range 1..255).
REQ-002 Port: clk  input  1  system clock; single clock domain, rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: left  input  1  left-turn request, level-sensitive.
REQ-005 Port: right  input  1  right-turn request, level-sensitive.
REQ-006 Port: hazard  input  1  hazard request, level-sensitive.
REQ-007 Port: brake  input  1  brake pedal, level-sensitive.
REQ-008 Port: lights_l  output  3  left lamps; bit0=la (innermost), bit1=lb, bit2=lc.
REQ-009 Port: lights_r  output  3  right lamps; bit0=ra (innermost), bit1=rb, bit2=rc.

Function
REQ-010 The block SHALL implement FSM states IDLE, L1, L2, L3, R1, R2, R3, HAZ_ON and DARK.
REQ-011 A prescaler counter SHALL count 0..TICK_DIV-1, wrap to 0, and assert tick when count==TICK_DIV-1; it SHALL be cleared on every IDLE exit.
REQ-012 In IDLE, the FSM SHALL evaluate requests on every clock (no tick needed), with priority: hazard or (left&right) -> HAZ_ON; else left -> L1; else right -> R1; else stay.
REQ-013 On tick: L1->L2->L3->DARK and R1->R2->R3->DARK; HAZ_ON->DARK; DARK->IDLE.
REQ-014 Between ticks, all non-IDLE states SHALL hold.
REQ-015 Once started, a turn sequence SHALL complete even if its request drops or the opposite request arrives.
REQ-016 Exception to REQ-015: hazard=1 at a tick in any L*/R* state SHALL force HAZ_ON instead of the normal successor.
REQ-017 State patterns: L1 lights_l=001, L2 lights_l=011, L3 lights_l=111, with lights_r=000 in all L* states.
REQ-018 State patterns: R1 lights_r=001, R2 lights_r=011, R3 lights_r=111, with lights_l=000 in all R* states.
REQ-019 State patterns: HAZ_ON both sides 111; DARK and IDLE both sides 000.
REQ-020 Brake overlay: with brake=1, the non-signalling side in L*/R* states SHALL show 111, and both sides in IDLE/DARK SHALL show 111; HAZ_ON is unaffected.
REQ-021 Outputs SHALL be registered from the current state and brake: a state entered at edge k appears on the lamps after edge k+1, and a brake change sampled at edge k appears after edge k+1.
REQ-022 With requests held, the sequence SHALL repeat indefinitely; each repetition contains one DARK step of TICK_DIV cycles followed by one IDLE cycle.
REQ-023 With TICK_DIV=1, every non-IDLE state SHALL last exactly one clock.

Reset
REQ-024 Assertion of reset SHALL immediately (asynchronously) force state=IDLE, prescaler=0, lights_l=000 and lights_r=000, including mid-sequence.
REQ-025 After reset deasserts, the first request SHALL be evaluated at the next rising clk edge, following REQ-012.

Structure
REQ-026 Package tail_light_pkg SHALL hold the state enum typedef and the 3-bit lamp pattern constants (OFF=000, ONE=001, TWO=011, ALL=111).
REQ-027 The prescaler SHALL be a sub-module named tick_prescaler, with ports clk, reset, clear and tick, and parameter TICK_DIV.
REQ-028 The FSM and the output registers SHALL reside in tail_light_ctrl.

Verification (TICK_DIV=4 unless stated)
REQ-029 Single-cycle left pulse in IDLE -> lights_l = 001, 011, 111 for 4 clocks each, then 000 for 4 clocks, then return to IDLE with lights_r=000 throughout.
REQ-030 left=right=1 held from IDLE -> both sides alternate 111 for 4 clocks and 000 for 5 clocks (4 DARK + 1 IDLE), repeating until released.
REQ-031 hazard rises during R2 -> at the next tick the state goes to HAZ_ON, and both sides show 111 one clock later.
REQ-032 brake=1 during a left sequence -> lights_r=111 while lights_l sequences normally; brake=1 in IDLE -> both sides 111; brake=1 during HAZ_ON -> pattern unchanged.
REQ-033 Reset asserted mid-L3, between clock edges -> both sides 000 with no clock edge; after release with left=1, the sequence restarts at L1.
REQ-034 TICK_DIV=1 with right held -> lights_r steps 001, 011, 111, 000 at one step per clock, with a one-cycle IDLE gap before each repeat.
